rect_motion_ctl: RTL and testbench

Parametrised vertical-motion controller for a drawn rectangle in the VGA game datapath.
- Counts a programmable tick period, drops the rectangle by STEP pixels per tick, and lifts it for a bounded number of ticks on a button press.
- Saturates at configurable top/bottom bounds, reports landing, and supports pause.
- Output ypos feeds the rectangle drawing stage; button inputs arrive already synchronised and debounced.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/rect_motion_ctl_tick_gen.sv | 40 ++++
 rtl/rect_motion_ctl.sv | 156 +++++++++++++++
 tb/tb_rect_motion_ctl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA game constants and the rectangle motion state type.
// Defaults assume a 600-line visible frame and a 4M-cycle motion tick.
package vga_pkg;

    localparam int unsigned VER_PIXELS         = 600;
    localparam int unsigned MOTION_Y_MAX       = VER_PIXELS - 1;
    localparam int unsigned MOTION_TICK_CYCLES = 4_000_000;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        RISE,
        LANDED
    } motion_state_t;

    // Counter width that stays legal for a modulus of 1.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/rect_motion_ctl_tick_gen.sv
// Modulo-TICK_CYCLES counter producing a one-cycle tick on its last count.
// clr restarts the phase; en low freezes the count and suppresses the tick.
module tick_gen
    import vga_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = MOTION_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned      CNT_W = cnt_width(TICK_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) & en;

endmodule

// File: rtl/rect_motion_ctl.sv
// Vertical motion controller for the game rectangle: timed fall, bounded
// lift on button press, saturation at top/bottom bounds, and pause.
module rect_motion_ctl
    import vga_pkg::*;
#(
    parameter int unsigned POS_W       = 12,
    parameter int unsigned TICK_CYCLES = MOTION_TICK_CYCLES,
    parameter int unsigned STEP        = 1,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = MOTION_Y_MAX,
    parameter int unsigned RISE_TICKS  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lift,
    input  logic             pause,
    output logic [POS_W-1:0] ypos,
    output logic             moving,
    output logic             landed,
    output logic             at_top
);

    if (TICK_CYCLES < 1) begin : g_bad_tick
        $error("rect_motion_ctl: TICK_CYCLES must be >= 1");
    end
    if (Y_MIN >= Y_MAX) begin : g_bad_bounds
        $error("rect_motion_ctl: Y_MIN must be below Y_MAX");
    end
    if (STEP < 1 || STEP > Y_MAX - Y_MIN) begin : g_bad_step
        $error("rect_motion_ctl: STEP must be in 1..Y_MAX-Y_MIN");
    end
    if (RISE_TICKS < 1) begin : g_bad_rise
        $error("rect_motion_ctl: RISE_TICKS must be >= 1");
    end
    if (64'(Y_MAX) >= (64'd1 << POS_W)) begin : g_bad_width
        $error("rect_motion_ctl: Y_MAX does not fit in POS_W bits");
    end

    localparam int unsigned      RC_W       = $clog2(RISE_TICKS + 1);
    localparam logic [POS_W-1:0] YMIN_V     = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] YMAX_V     = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] STEP_V     = POS_W'(STEP);
    localparam logic [POS_W-1:0] RISE_FLOOR = POS_W'(Y_MIN + STEP);
    localparam logic [RC_W-1:0]  RISE_V     = RC_W'(RISE_TICKS);

    motion_state_t    state_q, state_d;
    logic [POS_W-1:0] ypos_q, ypos_d;
    logic [RC_W-1:0]  rise_q, rise_d;
    logic             start_q, lift_q;
    logic             moving_q, moving_d;
    logic             landed_q, landed_d;
    logic             at_top_q, at_top_d;

    logic             start_e, lift_e;
    logic             tick, tick_clr;
    logic [POS_W:0]   fall_sum;
    logic [POS_W-1:0] fall_y, rise_y;

    // Phase restarts on every state change so the first step is a full period away.
    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .en   (~pause),
        .tick (tick)
    );

    // Pause masks edges and tick, which by itself freezes every transition below.
    assign start_e  = start & ~start_q & ~pause;
    assign lift_e   = lift & ~lift_q & ~pause;
    assign fall_sum = {1'b0, ypos_q} + {1'b0, STEP_V};
    assign fall_y   = (fall_sum >= {1'b0, YMAX_V}) ? YMAX_V : fall_sum[POS_W-1:0];
    assign rise_y   = (ypos_q <= RISE_FLOOR) ? YMIN_V : ypos_q - STEP_V;
    assign tick_clr = (state_d != state_q);

    always_comb begin
        state_d  = state_q;
        ypos_d   = ypos_q;
        rise_d   = rise_q;
        landed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                ypos_d = YMIN_V;
                if (start_e) begin
                    state_d = FALL;
                end
            end
            FALL: begin
                if (lift_e) begin
                    state_d = RISE;
                    rise_d  = RISE_V;
                end else if (tick) begin
                    ypos_d = fall_y;
                    if (fall_y == YMAX_V) begin
                        state_d  = LANDED;
                        landed_d = 1'b1;
                    end
                end
            end
            RISE: begin
                if (lift_e) begin
                    rise_d = RISE_V;
                end else if (tick) begin
                    ypos_d = rise_y;
                    rise_d = rise_q - 1'b1;
                    if (rise_q == RC_W'(1) || rise_y == YMIN_V) begin
                        state_d = FALL;
                    end
                end
            end
            LANDED: begin
                if (start_e) begin
                    state_d = FALL;
                    ypos_d  = YMIN_V;
                end
            end
            default: begin
                state_d = IDLE;
                ypos_d  = YMIN_V;
            end
        endcase
        moving_d = (state_d == FALL) || (state_d == RISE);
        at_top_d = (ypos_d == YMIN_V);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ypos_q   <= YMIN_V;
            rise_q   <= '0;
            start_q  <= 1'b0;
            lift_q   <= 1'b0;
            moving_q <= 1'b0;
            landed_q <= 1'b0;
            at_top_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ypos_q   <= ypos_d;
            rise_q   <= rise_d;
            start_q  <= start;
            lift_q   <= lift;
            moving_q <= moving_d;
            landed_q <= landed_d;
            at_top_q <= at_top_d;
        end
    end

    assign ypos   = ypos_q;
    assign moving = moving_q;
    assign landed = landed_q;
    assign at_top = at_top_q;

endmodule

// File: tb/tb_rect_motion_ctl.sv
// Self-checking bench for rect_motion_ctl: directed scenarios plus random
// button/pause/reset traffic compared against a behavioural model.
module tb_rect_motion_ctl;

    localparam int TC   = 4;
    localparam int ST   = 3;
    localparam int YMIN = 0;
    localparam int YMAX = 10;
    localparam int RT   = 2;
    localparam int PW   = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          lift  = 1'b0;
    logic          pause = 1'b0;
    logic [PW-1:0] ypos;
    logic          moving, landed, at_top;

    int n_checks = 0;
    int n_fail   = 0;

    rect_motion_ctl #(
        .POS_W      (PW),
        .TICK_CYCLES(TC),
        .STEP       (ST),
        .Y_MIN      (YMIN),
        .Y_MAX      (YMAX),
        .RISE_TICKS (RT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .lift  (lift),
        .pause (pause),
        .ypos  (ypos),
        .moving(moving),
        .landed(landed),
        .at_top(at_top)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 falling, 2 rising, 3 landed.
    // m_phase counts unpaused cycles since the last mode change, modulo TC.
    int m_mode = 0, m_y = YMIN, m_phase = 0, m_rise = 0;
    bit m_sp = 0, m_lp = 0, m_landed = 0;

    always @(posedge clk) begin
        bit se, le, stepnow;
        int prev;
        if (!rst_n) begin
            m_mode = 0; m_y = YMIN; m_phase = 0; m_rise = 0;
            m_sp = 0; m_lp = 0; m_landed = 0;
        end else begin
            se = start && !m_sp;
            le = lift && !m_lp;
            m_sp = start;
            m_lp = lift;
            m_landed = 0;
            if (!pause) begin
                prev    = m_mode;
                stepnow = (m_phase == TC - 1);
                m_phase = (m_phase + 1) % TC;
                case (m_mode)
                    0: if (se) m_mode = 1;
                    1: if (le) begin
                           m_mode = 2; m_rise = RT;
                       end else if (stepnow) begin
                           m_y = (m_y + ST > YMAX) ? YMAX : m_y + ST;
                           if (m_y == YMAX) begin m_mode = 3; m_landed = 1; end
                       end
                    2: if (le) begin
                           m_rise = RT;
                       end else if (stepnow) begin
                           m_y = (m_y - YMIN < ST) ? YMIN : m_y - ST;
                           m_rise = m_rise - 1;
                           if (m_rise == 0 || m_y == YMIN) m_mode = 1;
                       end
                    3: if (se) begin m_mode = 1; m_y = YMIN; end
                    default: m_mode = 0;
                endcase
                if (m_mode != prev) m_phase = 0;
            end
        end
    end

    function automatic logic [PW+2:0] model_vec();
        return {PW'(m_y), (m_mode == 1 || m_mode == 2), m_landed, (m_y == YMIN)};
    endfunction

    task automatic do_reset();
        rst_n = 0; start = 0; lift = 0; pause = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ypos !== PW'(YMIN)) begin n_fail++; $display("FAIL reset_ypos: got %0d expected %0d", ypos, YMIN); end
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b expected 0", moving); end
        n_checks++;
        if (landed !== 1'b0) begin n_fail++; $display("FAIL reset_landed: got %b expected 0", landed); end
        n_checks++;
        if (at_top !== 1'b1) begin n_fail++; $display("FAIL reset_at_top: got %b expected 1", at_top); end
    endtask

    task automatic test_fall_land();
        int ey;
        logic [PW+2:0] exp;
        do_reset();
        pulse_start();
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            ey  = (3 * (i / 4) > YMAX) ? YMAX : 3 * (i / 4);
            exp = {PW'(ey), (i < 16), (i == 16), (ey == 0)};
            n_checks++;
            if ({ypos, moving, landed, at_top} !== exp) begin
                n_fail++;
                $display("FAIL fall_land[%0d]: got y=%0d mv=%b ld=%b top=%b expected %h", i, ypos, moving, landed, at_top, exp);
            end
        end
    endtask

    task automatic test_lift_rise();
        int seq[5] = '{6, 3, 6, 9, 10};
        int ey;
        logic [PW+2:0] exp;
        do_reset();
        pulse_start();
        repeat (12) @(negedge clk);
        lift = 1;
        @(negedge clk);
        lift = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            ey  = (i < 4) ? 9 : seq[i / 4 - 1];
            exp = {PW'(ey), (i < 20), (i == 20), (ey == 0)};
            n_checks++;
            if ({ypos, moving, landed, at_top} !== exp) begin
                n_fail++;
                $display("FAIL lift_rise[%0d]: got y=%0d mv=%b ld=%b top=%b expected %h", i, ypos, moving, landed, at_top, exp);
            end
        end
    endtask

    task automatic test_lift_extend();
        int ey;
        logic [PW+2:0] exp;
        do_reset();
        pulse_start();
        repeat (12) @(negedge clk);
        lift = 1;
        @(negedge clk);
        lift = 0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (ypos !== PW'(6)) begin n_fail++; $display("FAIL extend_first_rise: got %0d expected 6", ypos); end
        lift = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            lift = 0;
            ey  = (i < 4) ? 6 : (i < 8) ? 3 : (i < 12) ? 0 : 3;
            exp = {PW'(ey), 1'b1, 1'b0, (ey == 0)};
            n_checks++;
            if ({ypos, moving, landed, at_top} !== exp) begin
                n_fail++;
                $display("FAIL lift_extend[%0d]: got y=%0d mv=%b ld=%b top=%b expected %h", i, ypos, moving, landed, at_top, exp);
            end
        end
    endtask

    task automatic test_start_hold();
        int n_land = 0;
        do_reset();
        start = 1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (landed === 1'b1) n_land++;
        end
        n_checks++;
        if (n_land != 1) begin n_fail++; $display("FAIL hold_landed_count: got %0d expected 1", n_land); end
        n_checks++;
        if ({ypos, moving} !== {PW'(YMAX), 1'b0}) begin
            n_fail++; $display("FAIL hold_final: got y=%0d mv=%b expected y=%0d mv=0", ypos, moving, YMAX);
        end
        start = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        n_checks++;
        if ({ypos, moving, landed, at_top} !== {PW'(0), 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL relaunch: got y=%0d mv=%b ld=%b top=%b expected y=0 mv=1 ld=0 top=1", ypos, moving, landed, at_top);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ypos !== PW'(3)) begin n_fail++; $display("FAIL relaunch_step: got %0d expected 3", ypos); end
        start = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ypos, moving} !== {PW'(6), 1'b1}) begin
            n_fail++; $display("FAIL start_in_fall: got y=%0d mv=%b expected y=6 mv=1", ypos, moving);
        end
    endtask

    task automatic test_pause();
        do_reset();
        pulse_start();
        repeat (10) @(negedge clk);
        n_checks++;
        if (ypos !== PW'(6)) begin n_fail++; $display("FAIL pause_setup: got %0d expected 6", ypos); end
        pause = 1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 5) lift = 1;
            n_checks++;
            if ({ypos, moving, landed, at_top} !== {PW'(6), 1'b1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL pause_hold[%0d]: got y=%0d mv=%b ld=%b top=%b expected y=6 mv=1 ld=0 top=0", j, ypos, moving, landed, at_top);
            end
        end
        pause = 0;
        @(negedge clk);
        n_checks++;
        if (ypos !== PW'(6)) begin n_fail++; $display("FAIL pause_release1: got %0d expected 6", ypos); end
        @(negedge clk);
        n_checks++;
        if ({ypos, moving} !== {PW'(9), 1'b1}) begin
            n_fail++; $display("FAIL pause_release2: got y=%0d mv=%b expected y=9 mv=1", ypos, moving);
        end
        lift = 0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({ypos, landed} !== {PW'(YMAX), 1'b1}) begin
            n_fail++; $display("FAIL pause_land: got y=%0d ld=%b expected y=%0d ld=1", ypos, landed, YMAX);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        repeat (4) @(negedge clk);
        lift = 1;
        @(negedge clk);
        lift = 0;
        n_checks++;
        if ({ypos, moving} !== {PW'(3), 1'b1}) begin
            n_fail++; $display("FAIL midrst_setup: got y=%0d mv=%b expected y=3 mv=1", ypos, moving);
        end
        @(negedge clk);
        rst_n = 0;
        pause = 1;
        @(negedge clk);
        rst_n = 1;
        pause = 0;
        n_checks++;
        if ({ypos, moving, landed, at_top} !== {PW'(0), 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL midrst_state: got y=%0d mv=%b ld=%b top=%b expected y=0 mv=0 ld=0 top=1", ypos, moving, landed, at_top);
        end
        start = 1;
        lift  = 1;
        @(negedge clk);
        start = 0;
        lift  = 0;
        n_checks++;
        if ({ypos, moving} !== {PW'(0), 1'b1}) begin
            n_fail++; $display("FAIL both_edges_launch: got y=%0d mv=%b expected y=0 mv=1", ypos, moving);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({ypos, moving} !== {PW'(3), 1'b1}) begin
            n_fail++; $display("FAIL both_edges_fall: got y=%0d mv=%b expected y=3 mv=1", ypos, moving);
        end
    endtask

    task automatic test_random();
        logic [PW+2:0] exp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) start = ~start;
            if ($urandom_range(0, 11) == 0) lift = ~lift;
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            rst_n = ($urandom_range(0, 799) != 0);
            @(negedge clk);
            exp = model_vec();
            n_checks++;
            if ({ypos, moving, landed, at_top} !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got y=%0d mv=%b ld=%b top=%b expected %h", n, ypos, moving, landed, at_top, exp);
            end
        end
        rst_n = 1;
        pause = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fall_land();
        test_lift_rise();
        test_lift_extend();
        test_start_hold();
        test_pause();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
